instr_assembler: RTL and testbench
==================================

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
- REQ-001 SHALL have port: clk_i  input  1  single clock; all state updates on posedge.
- REQ-002 SHALL have port: rst_n_i  input  1  reset; synchronous, active-low.
- REQ-003 SHALL have port: instr_i  input  HALF_WORD  fetched Thumb halfword.
- REQ-004 SHALL have port: addr_i  input  WORD  byte address of instr_i.
- REQ-005 SHALL have port: instr_valid_i  input  1  instr_i/addr_i valid this cycle.
- REQ-006 SHALL have port: stall_i  input  1  downstream stall; hold all state and outputs.
- REQ-007 SHALL have port: flush_i  input  1  discard the held prefix and the current input.
- REQ-008 SHALL have port: ready_o  output  1  equals ~stall_i & ~flush_i (combinational).
- REQ-009 SHALL have port: instr_word_o  output  WORD  assembled instruction; 32-bit = {prefix, suffix}; 16-bit = {16'h0, halfword}.
- REQ-010 SHALL have port: instr_pc_o  output  WORD  address of first halfword of instr_word_o.
- REQ-011 SHALL have port: instr_valid_o  output  1  instr_word_o is a complete instruction.
- REQ-012 SHALL have port: is_32bit_o  output  1  instr_word_o is a 32-bit encoding.
- REQ-013 SHALL have port: undef_o  output  1  32-bit prefix not legal in ARMv6-M (bits[15:11] = 11101 or 11111).
- REQ-014 SHALL have port: suffix_pending_o  output  1  a prefix is held awaiting its suffix.

Function
- REQ-015 Accept SHALL be instr_valid_i & ~stall_i & ~flush_i; no input is consumed otherwise.
- REQ-016 FSM SHALL have two states: IDLE (expect first halfword) and WAIT_SUFFIX (prefix held).
- REQ-017 In IDLE, an accepted halfword with bits[15:11] in {11101, 11110, 11111} SHALL be a prefix: store it and addr_i, go to WAIT_SUFFIX, and drive instr_valid_o=0 next cycle (bubble).
- REQ-018 In IDLE, any other accepted halfword SHALL drive, next cycle, instr_valid_o=1, is_32bit_o=0, undef_o=0, instr_word_o={16'h0,instr_i}, instr_pc_o=addr_i; stay in IDLE.
- REQ-019 In WAIT_SUFFIX, the next accepted halfword SHALL be taken as the suffix regardless of its encoding; next cycle drive instr_valid_o=1, is_32bit_o=1, instr_word_o={prefix,suffix}, instr_pc_o=prefix address; return to IDLE.
- REQ-020 undef_o SHALL be 1 with the completed 32-bit word when prefix bits[15:11] are 11101 or 11111, else 0; the suffix SHALL still be consumed.
- REQ-021 Latency SHALL be 1 cycle from accepting the final halfword to instr_valid_o.
- REQ-022 instr_valid_o SHALL be 0 in any cycle following a non-accepting, non-stalled cycle.
- REQ-023 While stall_i=1 and flush_i=0, all registers and outputs SHALL hold their values.
- REQ-024 flush_i SHALL take priority over stall_i and instr_valid_i: next cycle state=IDLE, instr_valid_o=0, suffix_pending_o=0, held prefix invalidated.
- REQ-025 suffix_pending_o SHALL be 1 exactly when state=WAIT_SUFFIX.

Reset
- REQ-026 On a rising clock edge with rst_n_i=0: state=IDLE, instr_valid_o=0, is_32bit_o=0, undef_o=0, suffix_pending_o=0, instr_word_o=0, instr_pc_o=0; reset overrides flush and stall.
- REQ-027 Reset during WAIT_SUFFIX SHALL discard the prefix; the first halfword after reset SHALL be decoded from IDLE.

Structure
- REQ-028 The state enum and the three 5-bit prefix codes SHALL live in the shared GENERAL_DEFS definitions next to WORD/HALF_WORD.
- REQ-029 Prefix detection SHALL be a package-level function; no sub-module is required.
- REQ-030 Outputs other than ready_o SHALL be registered.

Verification
- REQ-031 0x2005 at 0x100, valid -> next cycle valid=1, word=0x00002005, pc=0x100, is_32bit=0.
- REQ-032 0xF000 at 0x200, then 0xF802 at 0x202 -> bubble after the prefix; then valid=1, word=0xF000F802, pc=0x200, is_32bit=1, undef=0.
- REQ-033 0xF000, stall_i=1 for 3 cycles, then 0xF802 -> outputs frozen during the stall; exactly one valid output, 0xF000F802.
- REQ-034 0xF000, then flush_i=1 with 0xF802 valid, then 0x2005 -> no output for the flushed pair; then valid word=0x00002005, is_32bit=0.
- REQ-035 0xE800 then 0x0000 -> valid=1, word=0xE8000000, undef=1.
- REQ-036 rst_n_i=0 in WAIT_SUFFIX, then 0xF802 -> treated as a prefix (suffix_pending_o=1, no valid output).

Source files
------------

// File: rtl/instr_assembler_pkg.sv
// +----------------------------------------------------------------------------+
// | instr_assembler_pkg : shared general definitions (WORD/HALF_WORD, FSM       |
// | states, Thumb-2 prefix codes, prefix decode helpers).  Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

package instr_assembler_pkg;

  localparam int WORD      = 32;
  localparam int HALF_WORD = 16;

  typedef logic [WORD-1:0]      word_t;
  typedef logic [HALF_WORD-1:0] half_word_t;
  typedef logic [0:0]           state_t;

  localparam state_t c_st_idle        = 1'b0;
  localparam state_t c_st_wait_suffix = 1'b1;

  // bits[15:11] of the first halfword that mark a 32-bit encoding
  localparam logic [4:0] c_prefix_11101 = 5'b11101;
  localparam logic [4:0] c_prefix_11110 = 5'b11110;
  localparam logic [4:0] c_prefix_11111 = 5'b11111;

  function automatic logic is_prefix(input half_word_t hw);
    return (hw[15:11] == c_prefix_11101) ||
           (hw[15:11] == c_prefix_11110) ||
           (hw[15:11] == c_prefix_11111);
  endfunction

  // ARMv6-M only implements the 11110 group of 32-bit encodings
  function automatic logic is_undef_prefix(input half_word_t hw);
    return (hw[15:11] == c_prefix_11101) ||
           (hw[15:11] == c_prefix_11111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_assembler_if.sv
// +----------------------------------------------------------------------------+
// | instr_assembler_if : fetch-side inputs and assembled-instruction outputs.   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instr_assembler_if;
  import instr_assembler_pkg::*;

  half_word_t instr_i;
  word_t      addr_i;
  logic       instr_valid_i;
  logic       stall_i;
  logic       flush_i;
  logic       ready_o;
  word_t      instr_word_o;
  word_t      instr_pc_o;
  logic       instr_valid_o;
  logic       is_32bit_o;
  logic       undef_o;
  logic       suffix_pending_o;

  modport master (
    output instr_i, addr_i, instr_valid_i, stall_i, flush_i,
    input  ready_o, instr_word_o, instr_pc_o, instr_valid_o,
           is_32bit_o, undef_o, suffix_pending_o
  );

  modport slave (
    input  instr_i, addr_i, instr_valid_i, stall_i, flush_i,
    output ready_o, instr_word_o, instr_pc_o, instr_valid_o,
           is_32bit_o, undef_o, suffix_pending_o
  );

endinterface

`default_nettype wire

// File: rtl/instr_assembler.sv
// +----------------------------------------------------------------------------+
// | instr_assembler : joins Thumb halfwords into 16/32-bit instructions with    |
// | one cycle of latency, stall hold and flush.  Rev 1.0                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_assembler
  import instr_assembler_pkg::*;
(
  input  wire logic            clk_i,
  input  wire logic            rst_n_i,
  instr_assembler_if.slave     bus
);

  state_t     r_state;
  half_word_t r_prefix;
  word_t      r_prefix_addr;
  word_t      r_word;
  word_t      r_pc;
  logic       r_valid;
  logic       r_is_32bit;
  logic       r_undef;

  logic       w_accept;

  assign w_accept    = bus.instr_valid_i & ~bus.stall_i & ~bus.flush_i;
  assign bus.ready_o = ~bus.stall_i & ~bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state       <= c_st_idle;
      r_prefix      <= '0;
      r_prefix_addr <= '0;
      r_word        <= '0;
      r_pc          <= '0;
      r_valid       <= 1'b0;
      r_is_32bit    <= 1'b0;
      r_undef       <= 1'b0;
    end else if (bus.flush_i) begin
      r_state <= c_st_idle;
      r_valid <= 1'b0;
    end else if (bus.stall_i) begin
      // everything holds
    end else if (w_accept) begin
      if (r_state == c_st_idle) begin
        if (is_prefix(bus.instr_i)) begin
          r_prefix      <= bus.instr_i;
          r_prefix_addr <= bus.addr_i;
          r_state       <= c_st_wait_suffix;
          r_valid       <= 1'b0;
        end else begin
          r_word     <= {16'h0000, bus.instr_i};
          r_pc       <= bus.addr_i;
          r_valid    <= 1'b1;
          r_is_32bit <= 1'b0;
          r_undef    <= 1'b0;
        end
      end else begin
        // suffix is taken whatever its encoding
        r_word     <= {r_prefix, bus.instr_i};
        r_pc       <= r_prefix_addr;
        r_valid    <= 1'b1;
        r_is_32bit <= 1'b1;
        r_undef    <= is_undef_prefix(r_prefix);
        r_state    <= c_st_idle;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.instr_word_o     = r_word;
  assign bus.instr_pc_o       = r_pc;
  assign bus.instr_valid_o    = r_valid;
  assign bus.is_32bit_o       = r_is_32bit;
  assign bus.undef_o          = r_undef;
  assign bus.suffix_pending_o = (r_state == c_st_wait_suffix);

endmodule

`default_nettype wire

// File: tb/tb_instr_assembler.sv
// +----------------------------------------------------------------------------+
// | tb_instr_assembler : directed + random stimulus, queue scoreboard against  |
// | a halfword-stream reference model.  Rev 1.0                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_assembler;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        is32;
    logic        undef;
  } out_t;

  typedef struct {
    logic pend;
    logic has_out;
  } cyc_t;

  logic clk;
  logic rst_n;

  instr_assembler_if bus ();

  instr_assembler dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t        exp_q[$];
  cyc_t        cyc_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        started = 1'b0;

  // reference model: an optional held first halfword of a 32-bit instruction
  logic        m_have_prefix = 1'b0;
  logic [15:0] m_prefix      = '0;
  logic [31:0] m_prefix_addr = '0;
  logic [31:0] next_addr     = 32'h0000_1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] hw, input logic [31:0] a,
                       input logic st, input logic fl, input logic rn);
    cyc_t c;
    out_t o;
    logic [4:0] top;
    @(negedge clk);
    bus.instr_valid_i = v;
    bus.instr_i       = hw;
    bus.addr_i        = a;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    rst_n             = rn;
    c.has_out = 1'b0;
    if (!rn || fl) begin
      m_have_prefix = 1'b0;
    end else if (!st && v) begin
      top = hw[15:11];
      if (m_have_prefix) begin
        o.word  = {m_prefix, hw};
        o.pc    = m_prefix_addr;
        o.is32  = 1'b1;
        o.undef = (m_prefix[15:11] == 5'd29) || (m_prefix[15:11] == 5'd31);
        exp_q.push_back(o);
        c.has_out = 1'b1;
        m_have_prefix = 1'b0;
      end else if (top >= 5'd29) begin
        m_have_prefix = 1'b1;
        m_prefix      = hw;
        m_prefix_addr = a;
      end else begin
        o.word  = {16'h0000, hw};
        o.pc    = a;
        o.is32  = 1'b0;
        o.undef = 1'b0;
        exp_q.push_back(o);
        c.has_out = 1'b1;
      end
    end
    c.pend = m_have_prefix;
    cyc_q.push_back(c);
    started = 1'b1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // monitor: pops and compares after every active edge
  initial begin : monitor
    logic        s_rst, s_st, s_fl;
    logic [31:0] p_word, p_pc;
    logic        p_valid, p_is32, p_undef;
    cyc_t        c;
    out_t        o;
    p_word = '0; p_pc = '0; p_valid = 0; p_is32 = 0; p_undef = 0;
    wait (started);
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_st = bus.stall_i; s_fl = bus.flush_i;
      #1;
      check("ready_o", {31'h0, bus.ready_o}, {31'h0, ~bus.stall_i & ~bus.flush_i});
      if (cyc_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL cycle_queue: actual=empty required=entry at %0t", $time);
      end else begin
        c = cyc_q.pop_front();
        check("suffix_pending", {31'h0, bus.suffix_pending_o}, {31'h0, c.pend});
        if (!s_rst) begin
          check("reset_valid", {31'h0, bus.instr_valid_o}, 32'h0);
          check("reset_word",  bus.instr_word_o, 32'h0);
          check("reset_pc",    bus.instr_pc_o, 32'h0);
          check("reset_flags", {30'h0, bus.is_32bit_o, bus.undef_o}, 32'h0);
        end else if (s_st && !s_fl) begin
          check("stall_hold_word",  bus.instr_word_o, p_word);
          check("stall_hold_pc",    bus.instr_pc_o, p_pc);
          check("stall_hold_flags", {29'h0, bus.instr_valid_o, bus.is_32bit_o, bus.undef_o},
                                    {29'h0, p_valid, p_is32, p_undef});
        end else if (c.has_out) begin
          check("out_valid", {31'h0, bus.instr_valid_o}, 32'h1);
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL expected_queue: actual=empty required=entry at %0t", $time);
          end else begin
            o = exp_q.pop_front();
            check("out_word",  bus.instr_word_o, o.word);
            check("out_pc",    bus.instr_pc_o, o.pc);
            check("out_is32",  {31'h0, bus.is_32bit_o}, {31'h0, o.is32});
            check("out_undef", {31'h0, bus.undef_o}, {31'h0, o.undef});
          end
        end else begin
          check("no_out_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        end
      end
      p_word = bus.instr_word_o; p_pc = bus.instr_pc_o; p_valid = bus.instr_valid_o;
      p_is32 = bus.is_32bit_o;   p_undef = bus.undef_o;
    end
  end

  initial begin : stimulus
    logic [15:0] hw;
    logic [4:0]  top;
    logic        v, st, fl, rn;
    bus.instr_i = '0; bus.addr_i = '0; bus.instr_valid_i = 0;
    bus.stall_i = 0;  bus.flush_i = 0; rst_n = 0;

    drive(1'b1, 16'hF000, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();

    // 16-bit
    drive(1'b1, 16'h2005, 32'h100, 1'b0, 1'b0, 1'b1); idle();
    // 32-bit pair with bubble
    drive(1'b1, 16'hF000, 32'h200, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hF802, 32'h202, 1'b0, 1'b0, 1'b1); idle();
    // stall between prefix and suffix
    drive(1'b1, 16'hF000, 32'h300, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hF802, 32'h302, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'hF802, 32'h302, 1'b0, 1'b0, 1'b1); idle();
    // flush discards prefix and current suffix
    drive(1'b1, 16'hF000, 32'h400, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hF802, 32'h402, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 16'h2005, 32'h404, 1'b0, 1'b0, 1'b1); idle();
    // undefined prefix still consumes its suffix
    drive(1'b1, 16'hE800, 32'h500, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h0000, 32'h502, 1'b0, 1'b0, 1'b1); idle();
    drive(1'b1, 16'hF800, 32'h504, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hE000, 32'h506, 1'b0, 1'b0, 1'b1); idle();
    // reset while waiting for a suffix
    drive(1'b1, 16'hF000, 32'h600, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 32'h0,   1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hF802, 32'h602, 1'b0, 1'b0, 1'b1); idle();
    drive(1'b1, 16'h4770, 32'h604, 1'b0, 1'b0, 1'b1); idle();

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       top = 5'b11101;
        1:       top = 5'b11110;
        2:       top = 5'b11111;
        default: top = 5'($urandom_range(0, 31));
      endcase
      hw = {top, 11'($urandom)};
      v  = ($urandom_range(0, 99) < 75);
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 6);
      rn = ($urandom_range(0, 99) >= 3);
      drive(v, hw, next_addr, st, fl, rn);
      if (v && !st && !fl && rn) next_addr = next_addr + 32'd2;
    end

    idle(); idle(); idle();
    @(negedge clk);
    check("leftover_expected", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
